// File: rtl/jpeg_bit_drain_if.sv
// Bundle between jpeg_bit_drain, the bitstream FIFO read port and the byte-wide output stage.
// The master modport is the drain; the slave modport is the surrounding FIFO/packer side.
interface jpeg_bit_drain_if;
   logic        fifo_empty;
   logic        read_req;
   logic [90:0] read_data;
   logic        rdata_valid;
   logic        flush;
   logic [7:0]  out_byte;
   logic        out_valid;
   logic        out_ready;
   logic        flush_done;
   logic        busy;

   modport master (
      input  fifo_empty, read_data, rdata_valid, flush, out_ready,
      output read_req, out_byte, out_valid, flush_done, busy
   );

   modport slave (
      output fifo_empty, read_data, rdata_valid, flush, out_ready,
      input  read_req, out_byte, out_valid, flush_done, busy
   );
endinterface

// File: rtl/jpeg_bit_drain.sv
// Packs 91-bit VLC entries MSB-first into bytes and pads the final byte with 1s on flush; first byte valid 3 cycles after read_req.
// Output register stalls on !out_ready and reads pause while 8+ bits are held; JPEG_BYTE_STUFF_EN inserts 0x00 after every 0xFF.
module jpeg_bit_drain (
   input  logic             clk,
   input  logic             rst,
   jpeg_bit_drain_if.master bus
);
   typedef enum logic [1:0] {RUN, PAD, DONE} state_t;

   state_t      state_q, state_d;
   logic [95:0] acc_q, acc_d;
   logic [6:0]  cnt_q, cnt_d;
   logic        pend_q, pend_d;
   logic        stuff_q, stuff_d;
   logic        flush_req_q, flush_req_d;
   logic        read_req_q, read_req_d;
   logic        out_valid_q, out_valid_d;
   logic [7:0]  out_byte_q, out_byte_d;

   logic [6:0]  len;
   logic [83:0] code;
   logic        slot_free;
   logic [6:0]  take;
   logic [7:0]  byte_full;
   logic [7:0]  byte_pad;
   logic [7:0]  byte_new;
   logic        byte_load;
   logic [3:0]  pad_sh;
   logic        flush_seen;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q;
      stuff_d     = stuff_q;
      flush_req_d = flush_req_q;
      out_valid_d = out_valid_q;
      out_byte_d  = out_byte_q;
      take        = 7'd0;
      byte_load   = 1'b0;
      byte_new    = 8'h00;

      len       = (bus.read_data[90:84] > 7'd84) ? 7'd84 : bus.read_data[90:84];
      code      = bus.read_data[83:0] & ({84{1'b1}} >> (7'd84 - len));
      slot_free = !out_valid_q || bus.out_ready;
      byte_full = 8'(acc_q >> (cnt_q - 7'd8));
      // Partial byte: surviving bits move to the MSBs, the vacated LSBs become 1s.
      pad_sh    = 4'd8 - {1'b0, cnt_q[2:0]};
      byte_pad  = (acc_q[7:0] << pad_sh) | (8'hFF >> cnt_q[2:0]);

      read_req_d = !bus.fifo_empty && !pend_q && !bus.rdata_valid && (cnt_q < 7'd8);
      if (read_req_d) begin
         pend_d = 1'b1;
      end else if (bus.rdata_valid) begin
         pend_d = 1'b0;
      end

      if (slot_free) begin
         out_valid_d = 1'b0;
         if (stuff_q) begin
            out_valid_d = 1'b1;
            out_byte_d  = 8'h00;
            stuff_d     = 1'b0;
         end else if (cnt_q >= 7'd8) begin
            byte_load = 1'b1;
            byte_new  = byte_full;
            take      = 7'd8;
         end else if (state_q == PAD && cnt_q != 7'd0) begin
            byte_load = 1'b1;
            byte_new  = byte_pad;
            take      = cnt_q;
         end
      end

      if (byte_load) begin
         out_valid_d = 1'b1;
         out_byte_d  = byte_new;
`ifdef JPEG_BYTE_STUFF_EN
         if (byte_new == 8'hFF) begin
            stuff_d = 1'b1;
         end
`endif
      end

`ifndef JPEG_BYTE_STUFF_EN
      stuff_d = 1'b0;
`endif

      // Extraction reads the pre-shift accumulator, so a same-cycle load only adds below it.
      if (bus.rdata_valid) begin
         acc_d = (acc_q << len) | {12'd0, code};
         cnt_d = cnt_q - take + len;
      end else begin
         cnt_d = cnt_q - take;
      end

      flush_seen = flush_req_q || bus.flush;
      case (state_q)
         RUN: begin
            if (bus.flush) begin
               flush_req_d = 1'b1;
            end
            if (flush_seen && bus.fifo_empty && !pend_q && (cnt_q < 7'd8) && !stuff_q) begin
               state_d = PAD;
            end
         end
         PAD: begin
            if (cnt_q == 7'd0 && !stuff_q && slot_free) begin
               state_d = DONE;
            end
         end
         DONE: begin
            flush_req_d = 1'b0;
            state_d     = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         acc_q       <= '0;
         cnt_q       <= '0;
         pend_q      <= 1'b0;
         stuff_q     <= 1'b0;
         flush_req_q <= 1'b0;
         read_req_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_byte_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         stuff_q     <= stuff_d;
         flush_req_q <= flush_req_d;
         read_req_q  <= read_req_d;
         out_valid_q <= out_valid_d;
         out_byte_q  <= out_byte_d;
      end
   end

   assign bus.read_req   = read_req_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_byte   = out_byte_q;
   assign bus.flush_done = (state_q == DONE);
   assign bus.busy       = (cnt_q != 7'd0) || pend_q || out_valid_q || stuff_q ||
                           flush_req_q || (state_q != RUN);
endmodule

// File: tb/tb_jpeg_bit_drain.sv
// Bench for jpeg_bit_drain: FIFO responder, bit-queue reference model, per-cycle byte stream compare.
// Directed tests cover packing, flush padding, back-pressure, stuffing, edge lengths and mid-operation reset.
module tb_jpeg_bit_drain;
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   jpeg_bit_drain_if bus();
   jpeg_bit_drain dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [90:0] fifo_q[$];
   bit          mbits[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   int          xfer_cyc[$];
   int          read_req_cyc = -1;
   int          first_vld_cyc = -1;
   int          fd_cnt = 0;
   int          fd_cyc = -1;
   int          flush_cyc = 0;
   bit          req_seen = 0;
   bit          hold_v = 0;
   logic [7:0]  hold_b = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Reference model: a plain bit queue cut into bytes, MSB first.
   task automatic model_emit(input logic [7:0] b);
      exp_q.push_back(b);
`ifdef JPEG_BYTE_STUFF_EN
      if (b == 8'hFF) exp_q.push_back(8'h00);
`endif
   endtask

   task automatic model_push(input int len, input logic [83:0] c);
      int l;
      logic [7:0] b;
      l = (len > 84) ? 84 : len;
      for (int i = l - 1; i >= 0; i--) mbits.push_back(c[i]);
      while (mbits.size() >= 8) begin
         b = 8'h00;
         for (int k = 0; k < 8; k++) b = {b[6:0], mbits.pop_front()};
         model_emit(b);
      end
   endtask

   task automatic model_flush();
      logic [7:0] b;
      int n;
      n = mbits.size();
      if (n > 0) begin
         b = 8'hFF;
         for (int i = 0; i < n; i++) b[7-i] = mbits.pop_front();
         model_emit(b);
      end
   endtask

   task automatic push_entry(input int len, input logic [83:0] c);
      fifo_q.push_back({7'(len), c});
      model_push(len, c);
   endtask

   task automatic pulse_flush();
      bus.flush = 1'b1;
      flush_cyc = cyc;
      model_flush();
      step(1);
      bus.flush = 1'b0;
   endtask

   function automatic logic [31:0] pack_got();
      logic [31:0] v = 32'h0;
      foreach (got_q[i]) v = {v[23:0], got_q[i]};
      return v;
   endfunction

   task automatic new_test();
      got_q.delete();
      xfer_cyc.delete();
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      step(1);
      while ((bus.busy || fifo_q.size() != 0 || bus.rdata_valid || bus.read_req) && n < 400) begin
         step(1);
         n++;
      end
      check({name, "_idle_in_time"}, 32'(n < 400), 32'd1);
      check({name, "_all_bytes_seen"}, exp_q.size(), 32'd0);
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!bus.out_valid && n < 100) begin
         step(1);
         n++;
      end
      check({name, "_valid_in_time"}, 32'(n < 100), 32'd1);
   endtask

   task automatic wait_fd(input string name, input int fd0);
      int n = 0;
      while (fd_cnt == fd0 && n < 200) begin
         step(1);
         n++;
      end
      check({name, "_flush_done_in_time"}, 32'(n < 200), 32'd1);
   endtask

   // FIFO read port: data follows an accepted read_req by one cycle.
   initial begin
      bus.rdata_valid = 1'b0;
      bus.read_data   = '0;
      bus.fifo_empty  = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.rdata_valid = 1'b0;
         if (req_seen && fifo_q.size() > 0) begin
            bus.read_data   = fifo_q.pop_front();
            bus.rdata_valid = 1'b1;
         end
         req_seen = bus.read_req;
         if (bus.read_req && read_req_cyc < 0) read_req_cyc = cyc;
         bus.fifo_empty = (fifo_q.size() == 0);
      end
   end

   // Compare process: every accepted byte against the model, and handshake stability.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_v = 0;
         end else begin
            if (hold_v) begin
               check("hold_valid", 32'(bus.out_valid), 32'd1);
               check("hold_byte", 32'(bus.out_byte), 32'(hold_b));
            end
            if (bus.out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (bus.flush_done) begin
               fd_cnt++;
               fd_cyc = cyc;
            end
            if (bus.out_valid && bus.out_ready) begin
               got_q.push_back(bus.out_byte);
               xfer_cyc.push_back(cyc);
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL byte_stream: got %0h, expected no byte", bus.out_byte);
               end else begin
                  check("byte_stream", 32'(bus.out_byte), 32'(exp_q.pop_front()));
               end
            end
            hold_v = bus.out_valid && !bus.out_ready;
            hold_b = bus.out_byte;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int fd0;
      rst           = 1'b1;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      step(3);
      check("rst_read_req", 32'(bus.read_req), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_byte", 32'(bus.out_byte), 32'h00);
      check("rst_flush_done", 32'(bus.flush_done), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;
      step(2);

      // Single entry: 0x12, 0x34 back to back, 3 cycles after read_req.
      new_test();
      bus.out_ready = 1'b1;
      read_req_cyc  = -1;
      first_vld_cyc = -1;
      push_entry(16, 84'h1234);
      wait_idle("t1");
      check("t1_count", got_q.size(), 32'd2);
      check("t1_bytes", pack_got(), 32'h1234);
      check("t1_latency", 32'(first_vld_cyc - read_req_cyc), 32'd3);
      if (xfer_cyc.size() == 2) check("t1_consecutive", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd1);

      // Cross-entry packing then flush pad.
      new_test();
      fd0 = fd_cnt;
      push_entry(3, 84'b101);
      push_entry(5, 84'b00111);
      push_entry(4, 84'hA);
      step(2);
      pulse_flush();
      wait_fd("t2", fd0);
      wait_idle("t2");
      check("t2_count", got_q.size(), 32'd2);
      check("t2_bytes", pack_got(), 32'hA7AF);
      check("t2_flush_done_once", 32'(fd_cnt - fd0), 32'd1);
      if (xfer_cyc.size() == 2) check("t2_fd_after_last", 32'(fd_cyc - xfer_cyc[1]), 32'd1);

      // Back-pressure with an 84-bit entry loaded and another waiting in the FIFO.
      new_test();
      bus.out_ready = 1'b0;
      push_entry(84, 84'h0123456789ABCDEF01234);
      push_entry(8, 84'h5A);
      wait_valid("t3");
      check("t3_first_byte", 32'(bus.out_byte), 32'h01);
      for (int i = 0; i < 10; i++) begin
         step(1);
         check("t3_no_read_while_full", 32'(bus.read_req), 32'd0);
      end
      check("t3_still_valid", 32'(bus.out_valid), 32'd1);
      check("t3_still_byte", 32'(bus.out_byte), 32'h01);
      bus.out_ready = 1'b1;
      step(3);
      fd0 = fd_cnt;
      pulse_flush();
      wait_fd("t3", fd0);
      wait_idle("t3");
      check("t3_count", got_q.size(), 32'd12);
      if (got_q.size() == 12) begin
         check("t3_byte0", 32'(got_q[0]), 32'h01);
         check("t3_byte10", 32'(got_q[10]), 32'h45);
         check("t3_byte11", 32'(got_q[11]), 32'hAF);
      end

      // 0xFF from a whole entry and from a padded byte.
      new_test();
      fd0 = fd_cnt;
      push_entry(8, 84'hFF);
      push_entry(4, 84'hF);
      step(2);
      pulse_flush();
      wait_fd("t4", fd0);
      wait_idle("t4");
`ifdef JPEG_BYTE_STUFF_EN
      check("t4_count", got_q.size(), 32'd4);
      check("t4_bytes", pack_got(), 32'hFF00FF00);
`else
      check("t4_count", got_q.size(), 32'd2);
      check("t4_bytes", pack_got(), 32'h0000FFFF);
`endif

      // len=0 entry in the middle of a byte, then a len=127 entry clamped to 84.
      new_test();
      fd0 = fd_cnt;
      push_entry(4, 84'h9);
      push_entry(0, 84'hABC);
      push_entry(4, 84'h6);
      push_entry(127, 84'h123456789ABCDEF012345);
      step(2);
      pulse_flush();
      wait_fd("t5", fd0);
      wait_idle("t5");
      check("t5_count", got_q.size(), 32'd12);
      if (got_q.size() == 12) begin
         check("t5_len0_byte", 32'(got_q[0]), 32'h96);
         check("t5_first_long", 32'(got_q[1]), 32'h12);
         check("t5_last_pad", 32'(got_q[11]), 32'h5F);
      end

      // Flush with nothing buffered.
      new_test();
      fd0 = fd_cnt;
      pulse_flush();
      wait_fd("t5e", fd0);
      check("t5e_fd_delay", 32'(fd_cyc - flush_cyc), 32'd2);
      wait_idle("t5e");
      check("t5e_no_bytes", got_q.size(), 32'd0);

      // Reset while a byte is held and 20 bits remain.
      new_test();
      bus.out_ready = 1'b0;
      push_entry(28, 84'hABCDEF1);
      wait_valid("t6");
      step(1);
      rst = 1'b1;
      #1;
      check("t6_read_req", 32'(bus.read_req), 32'd0);
      check("t6_out_valid", 32'(bus.out_valid), 32'd0);
      check("t6_out_byte", 32'(bus.out_byte), 32'h00);
      check("t6_flush_done", 32'(bus.flush_done), 32'd0);
      check("t6_busy", 32'(bus.busy), 32'd0);
      fifo_q.delete();
      exp_q.delete();
      mbits.delete();
      step(2);
      rst = 1'b0;
      step(1);
      new_test();
      bus.out_ready = 1'b1;
      push_entry(16, 84'hBEEF);
      wait_idle("t6");
      check("t6_count", got_q.size(), 32'd2);
      check("t6_bytes", pack_got(), 32'hBEEF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/jpeg_bit_drain.md
# jpeg_bit_drain

Read-side consumer for the JPEG encoder's 91-bit bitstream FIFO. It pops variable-length code entries, packs them MSB-first into a bit accumulator, and emits a byte stream with valid/ready handshake toward the output packer. It sits between `sync_fifo_ff` (read port) and the byte-wide output stage. It also performs the end-of-image flush, padding the final partial byte with 1s.

## Interface
- No parameters. Widths are fixed: entry 91 bits, byte 8 bits.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fifo_empty` in 1: FIFO empty flag.
- `read_req` out 1: one-cycle registered pop request to the FIFO.
- `read_data` in 91: FIFO entry. `[90:84]` is len (bit count); `[83:0]` holds code bits, right-justified.
- `rdata_valid` in 1: `read_data` is valid this cycle. Arrives one cycle after an accepted `read_req`.
- `flush` in 1: one-cycle pulse requesting an end-of-image drain and pad.
- `out_byte` out 8: output byte.
- `out_valid` out 1: `out_byte` is valid.
- `out_ready` in 1: downstream accepts the byte.
- `flush_done` out 1: one-cycle pulse when the flush completes.
- `busy` out 1: high when bits are held, a read is pending, `out_valid` is high, or a flush is in progress.

## Operation
- **Accumulator:** `acc[95:0]` and `cnt[6:0]` (0..91 valid bits, LSB-justified). The oldest bit is `acc[cnt-1]`.
- **Read issue:** `read_req` rises for one cycle when all of the following hold:
  - `!fifo_empty`
  - no read pending
  - `!rdata_valid`
  - `cnt < 8`
  - A pending flag is set on `read_req` and cleared on `rdata_valid`.
- **Load on `rdata_valid`:**
  - `len = min(read_data[90:84], 84)`.
  - `acc <= (acc << len) | (read_data[83:0] & mask(len))`; `cnt += len`.
  - An entry with len = 0 is consumed with no effect.
- **Output register:** one stage, slot free when `!out_valid` or `out_ready`. If the slot is free:
  - If `stuff_pending`: load 0x00 and clear `stuff_pending`.
  - Otherwise, if `cnt >= 8`: load `acc[cnt-1:cnt-8]` and subtract 8 from `cnt`.
- **Simultaneous events:** a load and a byte extraction in the same cycle give `cnt_next = cnt + len - 8`. The extracted byte is taken from the pre-shift `acc`.
- **FSM states:** RUN, PAD, DONE.
  - **RUN:** `flush` latches `flush_req`.
  - **RUN -> PAD** when all of the following hold: `flush_req`, `fifo_empty`, no read pending, `cnt < 8`, `!stuff_pending`.
  - **PAD:**
    - If `cnt > 0` and the slot is free: load `{acc[cnt-1:0], 1s}` (8 bits), set `cnt = 0`, apply the stuffing rule.
    - When `cnt == 0`, `!stuff_pending`, and (`!out_valid` or `out_ready`): go to DONE.
  - **DONE:** pulse `flush_done` for one cycle, clear `flush_req`, return to RUN.
- `flush` asserted while `flush_req` is already set is ignored.

## Timing
- **Reset values:** `read_req=0`, `out_valid=0`, `out_byte=0x00`, `flush_done=0`, `busy=0`; `cnt=0`, pending=0, `stuff_pending=0`; state RUN.
- **Mid-operation reset:** all held bits and any pending read are discarded.
- **Latency:**
  - `read_req` in cycle N -> `rdata_valid` in N+1 -> `cnt` updated at the end of N+1.
  - The first byte is loaded at the end of N+2 and is visible with `out_valid` in N+3.
- **Sustained rate:** one byte per cycle while `out_ready` is high and bits are available.
- **Handshake:**
  - `out_byte` is stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a transfer.
- **Back-pressure:** `cnt` cannot exceed 91, because a read issues only when `cnt < 8`.
- **Flush with nothing buffered:** `flush_done` pulses 2 cycles after `flush` (RUN->PAD, PAD->DONE).

## Configuration
- **Macro `JPEG_BYTE_STUFF_EN`.**
  - **Defined:** every output byte equal to 0xFF, including a padded byte, sets `stuff_pending`, and the next output slot carries 0x00. `busy` stays high until the stuffed byte is accepted.
  - **Undefined:** no stuffing; `stuff_pending` is tied to 0.

## Test plan
- **Single entry:** reset, then push one entry (len=16, bits=0x1234), `out_ready=1` -> bytes 0x12, 0x34 in consecutive cycles. The first byte appears 3 cycles after `read_req`.
- **Cross-entry packing and flush:** entries (len=3, 0b101), (len=5, 0b00111), (len=4, 0xA), then `flush` -> bytes 0xA7 then 0xAF (pad with 1s). `flush_done` pulses one cycle after the last byte is accepted.
- **Back-pressure:** hold `out_ready=0` for 10 cycles with an entry of len=84 loaded -> `out_valid` held with a stable byte. `read_req` stays low until `cnt < 8`. No bytes are lost once `out_ready` rises.
- **Stuffing with `JPEG_BYTE_STUFF_EN` defined:** entry (len=8, 0xFF) -> bytes 0xFF, 0x00. Without the macro -> 0xFF only.
- **Edge entries and empty flush:** entry with len=0 -> no output and `cnt` unchanged. Entry with len=127 -> treated as 84. `flush` with `cnt=0` and the FIFO empty -> `flush_done` 2 cycles later and no bytes.
- **Mid-operation reset:** assert `rst` while `out_valid=1` and `cnt=20` -> all outputs at reset values immediately. After release, the next entry starts cleanly.
